// File: rtl/target_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// target_sequencer_pkg
// Shared definitions for the target_sequencer game-round engine:
//   - state_t       : round-engine FSM states
//   - WIN_L0..WIN_L3: display window length in ticks for difficulty 0..3
//   - LFSR_TAPS     : Galois tap mask for x^20 + x^17 + 1
//   - LFSR_FALLBACK_SEED : seed used at reset and when the upstream seed is 0
//   - lfsr_next()   : one Galois step (shift right, xor taps when lsb set)
//   - window_ticks(): level -> window length lookup
// -----------------------------------------------------------------------------
package target_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SHOW = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [9:0] WIN_L0 = 10'd800;
  localparam logic [9:0] WIN_L1 = 10'd500;
  localparam logic [9:0] WIN_L2 = 10'd300;
  localparam logic [9:0] WIN_L3 = 10'd150;

  localparam logic [19:0] LFSR_TAPS          = 20'h90000;
  localparam logic [19:0] LFSR_FALLBACK_SEED = 20'hACE1;

  // Right-shifting Galois form: the bit shifted out of position 0 feeds
  // back into the tap positions (bits 19 and 16).
  function automatic logic [19:0] lfsr_next(input logic [19:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 20'h00000);
  endfunction

  function automatic logic [9:0] window_ticks(input logic [1:0] lvl);
    case (lvl)
      2'd0:    window_ticks = WIN_L0;
      2'd1:    window_ticks = WIN_L1;
      2'd2:    window_ticks = WIN_L2;
      default: window_ticks = WIN_L3;
    endcase
  endfunction

endpackage

// File: rtl/target_sequencer_lfsr20.sv
// -----------------------------------------------------------------------------
// lfsr20
// 20-bit Galois LFSR (x^20 + x^17 + 1) with synchronous load.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset (register <= fallback seed)
//   load     in   load load_val this cycle (wins over step)
//   load_val in   20-bit value to load (parent guarantees non-zero)
//   step     in   advance the register by one Galois step
//   q        out  current register value
// -----------------------------------------------------------------------------
module lfsr20
  import target_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [19:0] load_val,
  input  logic        step,
  output logic [19:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= LFSR_FALLBACK_SEED;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/target_sequencer.sv
// -----------------------------------------------------------------------------
// target_sequencer
// Game-round engine. A start strobe seeds the LFSR from the upstream random
// value and latches the difficulty level; the engine then shows ROUNDS
// targets (positions 0..7), each for a level-dependent window of ticks,
// scoring keypad presses as hits or misses, with GAP_TICKS blank ticks
// between targets. done is raised after the last round.
//
// Build option: define TARGET_SEQ_STREAK_EN to enable the streak bonus
// (a hit that makes the consecutive-hit streak a multiple of 3 scores 2).
// Without it every hit scores exactly 1.
//
// Parameters:
//   ROUNDS     targets per game (1..31)
//   GAP_TICKS  blank ticks between targets (1..1023)
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         begin a new game (any state)
//   seed[19:0]    upstream random value, used as LFSR seed at start
//   level[1:0]    difficulty, sampled at start
//   tick          timebase strobe
//   key_valid     keypad press strobe, key_code[2:0] qualified by it
//   target[2:0]   current target position
//   target_valid  target is being shown
//   hit, miss     one-cycle result pulses
//   score[7:0]    saturating hit score
//   round[4:0]    targets issued this game
//   busy          game in progress
//   done          game finished
//   state_dbg     current FSM state, for observation only
//
// Input strobes (start, tick, key_valid) are single-cycle qualifiers with no
// back-pressure: every strobe is accepted in the cycle it is high, and is
// simply ignored in states that have no use for it.
// -----------------------------------------------------------------------------
module target_sequencer
  import target_sequencer_pkg::*;
#(
  parameter int ROUNDS    = 16,
  parameter int GAP_TICKS = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] seed,
  input  logic [1:0]  level,
  input  logic        tick,
  input  logic        key_valid,
  input  logic [2:0]  key_code,
  output logic [2:0]  target,
  output logic        target_valid,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  score,
  output logic [4:0]  round,
  output logic        busy,
  output logic        done,
  output state_t      state_dbg
);

  localparam logic [4:0] ROUNDS_L = ROUNDS[4:0];
  localparam logic [9:0] GAP_L    = GAP_TICKS[9:0];

  state_t      state;
  logic [1:0]  level_q;
  logic [9:0]  win_cnt;
  logic [9:0]  gap_cnt;

  logic [19:0] lfsr_q;
  logic [19:0] lfsr_load_val;
  logic [19:0] lfsr_peek;
  logic        lfsr_step;
  logic        lfsr_peek_unused;
  logic [2:0]  cand;
  logic [2:0]  next_target;

  logic        key_is_hit;
  logic        window_expires;
  logic [7:0]  score_inc;
  logic [8:0]  score_sum;
  logic [7:0]  score_sat;

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Target generation. The candidate comes from the value the LFSR takes on
  // this very edge, so the step is previewed combinationally here and the
  // sub-module commits the same step in parallel.
  // ---------------------------------------------------------------------------
  assign lfsr_load_val    = (seed == 20'h00000) ? LFSR_FALLBACK_SEED : seed;
  assign lfsr_step        = (state == ST_LOAD);
  assign lfsr_peek        = lfsr_next(lfsr_q);
  assign lfsr_peek_unused = ^lfsr_peek[19:3];
  assign cand             = lfsr_peek[2:0];
  // round == 0 means this is the first target of the game: no repeat rule.
  assign next_target      = ((round != 5'd0) && (cand == target)) ? cand + 3'd1 : cand;

  lfsr20 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .load_val (lfsr_load_val),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // ---------------------------------------------------------------------------
  // Score increment
  // ---------------------------------------------------------------------------
  assign key_is_hit     = (key_code == target);
  assign window_expires = tick && (win_cnt == 10'd1);

`ifdef TARGET_SEQ_STREAK_EN
  // Streak never exceeds ROUNDS (<= 31) because start clears it.
  logic [4:0] streak;
  logic [4:0] streak_inc;

  assign streak_inc = streak + 5'd1;
  assign score_inc  = ((streak_inc % 5'd3) == 5'd0) ? 8'd2 : 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= 5'd0;
    end else if (start) begin
      streak <= 5'd0;
    end else if (state == ST_SHOW) begin
      if (key_valid) begin
        streak <= key_is_hit ? streak_inc : 5'd0;
      end else if (window_expires) begin
        streak <= 5'd0;
      end
    end
  end
`else
  assign score_inc = 8'd1;
`endif

  assign score_sum = {1'b0, score} + {1'b0, score_inc};
  assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

  // ---------------------------------------------------------------------------
  // Round engine FSM. All outputs are registered here alongside the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      level_q      <= 2'd0;
      win_cnt      <= 10'd0;
      gap_cnt      <= 10'd0;
      target       <= 3'd0;
      target_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      score        <= 8'd0;
      round        <= 5'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;

      if (start) begin
        // start overrides whatever the current state would have done
        level_q      <= level;
        score        <= 8'd0;
        round        <= 5'd0;
        done         <= 1'b0;
        busy         <= 1'b1;
        target_valid <= 1'b0;
        state        <= ST_LOAD;
      end else begin
        case (state)
          ST_LOAD: begin
            target       <= next_target;
            target_valid <= 1'b1;
            round        <= round + 5'd1;
            win_cnt      <= window_ticks(level_q);
            state        <= ST_SHOW;
          end

          ST_SHOW: begin
            // A press is evaluated first; a window expiring on the same
            // cycle as a press is deliberately ignored.
            if (key_valid) begin
              target_valid <= 1'b0;
              gap_cnt      <= GAP_L;
              state        <= ST_GAP;
              if (key_is_hit) begin
                hit   <= 1'b1;
                score <= score_sat;
              end else begin
                miss  <= 1'b1;
              end
            end else if (tick) begin
              if (win_cnt == 10'd1) begin
                miss         <= 1'b1;
                target_valid <= 1'b0;
                gap_cnt      <= GAP_L;
                state        <= ST_GAP;
              end else begin
                win_cnt <= win_cnt - 10'd1;
              end
            end
          end

          ST_GAP: begin
            if (tick) begin
              if (gap_cnt == 10'd1) begin
                if (round < ROUNDS_L) begin
                  state <= ST_LOAD;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
                end
              end else begin
                gap_cnt <= gap_cnt - 10'd1;
              end
            end
          end

          ST_DONE: begin
            state <= ST_DONE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_target_sequencer.sv
// -----------------------------------------------------------------------------
// tb_target_sequencer
// Directed and randomized stimulus for target_sequencer, checked against a
// behavioural model of the game rules (seeded LFSR sequence, repeat
// avoidance, scoring with optional streak bonus).
// -----------------------------------------------------------------------------
module tb_target_sequencer;
  import target_sequencer_pkg::*;

  localparam int ROUNDS    = 16;
  localparam int GAP_TICKS = 200;

`ifdef TARGET_SEQ_STREAK_EN
  localparam bit STREAK = 1'b1;
`else
  localparam bit STREAK = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] seed;
  logic [1:0]  level;
  logic        tick;
  logic        key_valid;
  logic [2:0]  key_code;
  logic [2:0]  target;
  logic        target_valid;
  logic        hit;
  logic        miss;
  logic [7:0]  score;
  logic [4:0]  round;
  logic        busy;
  logic        done;
  state_t      state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  target_sequencer #(
    .ROUNDS    (ROUNDS),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .level        (level),
    .tick         (tick),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .target       (target),
    .target_valid (target_valid),
    .hit          (hit),
    .miss         (miss),
    .score        (score),
    .round        (round),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model of the game rules
  // ---------------------------------------------------------------------------
  int win_ticks[4] = '{800, 500, 300, 150};
  int m_lfsr;
  int m_target;
  int m_round;
  int m_score;
  int m_streak;
  logic [2:0] prev_shown;

  task automatic m_start(input int s);
    m_lfsr   = (s == 0) ? 'hACE1 : s;
    m_round  = 0;
    m_score  = 0;
    m_streak = 0;
    m_target = 0;
  endtask

  // Polynomial x^20 + x^17 + 1 in right-shift Galois form: halve the state,
  // and when an odd bit falls out, fold it back into positions 19 and 16.
  task automatic m_new_target();
    int c;
    if ((m_lfsr % 2) == 1) m_lfsr = (m_lfsr / 2) ^ ((1 << 19) | (1 << 16));
    else                   m_lfsr = m_lfsr / 2;
    c = m_lfsr % 8;
    if (m_round > 0 && c == m_target) c = (c + 1) % 8;
    m_target = c;
    m_round  = m_round + 1;
  endtask

  task automatic m_hit();
    m_streak = m_streak + 1;
    if (STREAK && (m_streak % 3) == 0) m_score = m_score + 2;
    else                               m_score = m_score + 1;
    if (m_score > 255) m_score = 255;
  endtask

  task automatic m_miss();
    m_streak = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic one_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic do_start(input logic [19:0] s, input logic [1:0] l);
    seed  = s;
    level = l;
    start = 1'b1;
    step();
    start = 1'b0;
    m_start(int'(s));
    chk("start_busy", busy, 1);
    chk("start_round", round, 0);
    chk("start_score", score, 0);
    chk("start_done", done, 0);
    chk("start_tvalid", target_valid, 0);
  endtask

  // One cycle from LOAD to SHOW; target must match the model.
  task automatic show_next();
    step();
    m_new_target();
    chk("show_tvalid", target_valid, 1);
    chk("show_target", target, m_target);
    chk("show_round", round, m_round);
    chk("show_busy", busy, 1);
    if (m_round > 1) chk("show_no_repeat", (target != prev_shown), 1);
    prev_shown = target;
  endtask

  task automatic press(input logic [2:0] code, input bit with_tick);
    key_valid = 1'b1;
    key_code  = code;
    tick      = with_tick;
    step();
    key_valid = 1'b0;
    tick      = 1'b0;
    if (int'(code) == m_target) m_hit();
    else                        m_miss();
    chk("press_hit", hit, (int'(code) == m_target));
    chk("press_miss", miss, (int'(code) != m_target));
    chk("press_tvalid", target_valid, 0);
    chk("press_score", score, m_score);
    step();
    chk("press_hit_width", hit, 0);
    chk("press_miss_width", miss, 0);
  endtask

  task automatic timeout(input int lvl);
    for (int i = 0; i < win_ticks[lvl] - 1; i++) one_tick();
    chk("pre_expire_tvalid", target_valid, 1);
    chk("pre_expire_miss", miss, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    m_miss();
    chk("expire_miss", miss, 1);
    chk("expire_hit", hit, 0);
    chk("expire_tvalid", target_valid, 0);
    chk("expire_score", score, m_score);
    step();
    chk("expire_miss_width", miss, 0);
  endtask

  // Runs the whole gap; on return the DUT has just taken the final gap tick.
  task automatic run_gap();
    for (int i = 0; i < GAP_TICKS - 1; i++) begin
      one_tick();
      if (i == 10) begin
        key_valid = 1'b1;
        key_code  = target;
        step();
        key_valid = 1'b0;
        chk("gap_key_ignored", hit | miss, 0);
      end
    end
    chk("gap_tvalid", target_valid, 0);
    chk("gap_target_held", target, m_target);
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic play_round(input int lvl, input bit randomized);
    int a;
    int pre;
    a = randomized ? int'($urandom_range(0, 2)) : 0;
    case (a)
      0: begin
        pre = $urandom_range(0, 20);
        for (int i = 0; i < pre; i++) one_tick();
        press(3'(m_target), 1'b0);
      end
      1: press(3'(m_target) ^ 3'($urandom_range(1, 7)), 1'b0);
      default: timeout(lvl);
    endcase
  endtask

  task automatic play_game(input int lvl, input bit randomized);
    for (int r = 1; r <= ROUNDS; r++) begin
      play_round(lvl, randomized);
      run_gap();
      if (r < ROUNDS) begin
        show_next();
      end else begin
        chk("final_done", done, 1);
        chk("final_busy", busy, 0);
        chk("final_round", round, ROUNDS);
        chk("final_score", score, m_score);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    seed       = 20'h0;
    level      = 2'd0;
    tick       = 1'b0;
    key_valid  = 1'b0;
    key_code   = 3'd0;
    prev_shown = 3'd0;
    m_start(0);

    step();
    step();
    chk("rst_tvalid", target_valid, 0);
    chk("rst_target", target, 0);
    chk("rst_score", score, 0);
    chk("rst_round", round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    rst_n = 1'b1;
    step();

    // IDLE ignores keys and ticks
    key_valid = 1'b1;
    key_code  = 3'd3;
    tick      = 1'b1;
    step();
    key_valid = 1'b0;
    tick      = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_hit_miss", hit | miss, 0);
    chk("idle_tvalid", target_valid, 0);

    // Seed 0 falls back to 20'hACE1; one Galois step gives 20'h95670 -> target 0
    do_start(20'h0, 2'd0);
    show_next();
    chk("first_target_const", target, 0);
    press(3'd0, 1'b0);
    chk("first_hit_score", score, 1);
    run_gap();
    show_next();
    chk("second_round", round, 2);

    // Wrong code: miss, score unchanged
    press(3'(m_target) ^ 3'd1, 1'b0);
    chk("wrong_score_kept", score, 1);
    run_gap();
    show_next();

    // Correct key on the expiring tick: key wins, no timeout
    for (int i = 0; i < win_ticks[0] - 1; i++) one_tick();
    press(3'(m_target), 1'b1);
    chk("coincident_score", score, 2);
    run_gap();
    show_next();

    // Reset while a target is shown
    rst_n = 1'b0;
    step();
    chk("midrst_tvalid", target_valid, 0);
    chk("midrst_score", score, 0);
    chk("midrst_round", round, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    step();

    // Level 3 timeout after exactly 150 ticks, then next target after the gap
    do_start(20'($urandom_range(1, 20'hFFFFF)), 2'd3);
    show_next();
    timeout(3);
    run_gap();
    show_next();
    chk("l3_round2", round, 2);

    // Full game, every target hit
    do_start(20'($urandom), 2'($urandom_range(0, 3)));
    show_next();
    play_game(0, 1'b0);
    chk("allhit_score_const", score, STREAK ? 21 : 16);
    key_valid = 1'b1;
    key_code  = target;
    tick      = 1'b1;
    step();
    key_valid = 1'b0;
    tick      = 1'b0;
    step();
    chk("done_held", done, 1);
    chk("done_round_held", round, ROUNDS);
    chk("done_score_held", score, m_score);

    // Full game with random hits, wrong keys and timeouts at level 3
    do_start(20'($urandom), 2'd3);
    show_next();
    play_game(3, 1'b1);

    // Restart from the gap of round 5
    do_start(20'($urandom), 2'd1);
    show_next();
    for (int r = 1; r <= 5; r++) begin
      press(3'(m_target), 1'b0);
      if (r < 5) begin
        run_gap();
        show_next();
      end
    end
    chk("pre_restart_round", round, 5);
    for (int i = 0; i < 50; i++) one_tick();
    do_start(20'($urandom_range(1, 20'hFFFFF)), 2'd2);
    show_next();
    chk("restart_round", round, 1);
    chk("restart_score", score, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
